// File: rtl/vm_pkg.sv
// Shared vending-machine definitions.
//  - state_t : front-end FSM encoding (IDLE / COLLECT / DONE)
//  - MONEY_W : width of every money quantity; output_handler uses it too
//  - DEF_*   : default coin credits, item prices and the credit ceiling
package vm_pkg;

  localparam int MONEY_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [MONEY_W-1:0] DEF_COIN0_VAL = 8'd5;
  localparam logic [MONEY_W-1:0] DEF_COIN1_VAL = 8'd10;
  localparam logic [MONEY_W-1:0] DEF_COIN2_VAL = 8'd20;
  localparam logic [MONEY_W-1:0] DEF_COIN3_VAL = 8'd50;

  localparam logic [MONEY_W-1:0] DEF_PRICE0 = 8'd15;
  localparam logic [MONEY_W-1:0] DEF_PRICE1 = 8'd25;
  localparam logic [MONEY_W-1:0] DEF_PRICE2 = 8'd30;
  localparam logic [MONEY_W-1:0] DEF_PRICE3 = 8'd45;

  localparam logic [MONEY_W-1:0] DEF_MAX_SUM = 8'd255;

endpackage

// File: rtl/coin_accumulator.sv
// Coin credit adder (purely combinational).
// Ports:
//  sum       in  current accumulated credit
//  coin_type in  coin denomination code
//  next_sum  out sum + coin credit (low MONEY_W bits; valid when !overflow)
//  overflow  out the coin would take the credit above MAX_SUM
module coin_accumulator
  import vm_pkg::*;
#(
  parameter logic [MONEY_W-1:0] COIN0_VAL = DEF_COIN0_VAL,
  parameter logic [MONEY_W-1:0] COIN1_VAL = DEF_COIN1_VAL,
  parameter logic [MONEY_W-1:0] COIN2_VAL = DEF_COIN2_VAL,
  parameter logic [MONEY_W-1:0] COIN3_VAL = DEF_COIN3_VAL,
  parameter logic [MONEY_W-1:0] MAX_SUM   = DEF_MAX_SUM
) (
  input  logic [MONEY_W-1:0] sum,
  input  logic [1:0]         coin_type,
  output logic [MONEY_W-1:0] next_sum,
  output logic               overflow
);

  logic [MONEY_W-1:0] coin_val;
  logic [MONEY_W:0]   wide_sum;

  always_comb begin
    coin_val = COIN0_VAL;
    case (coin_type)
      2'b00:   coin_val = COIN0_VAL;
      2'b01:   coin_val = COIN1_VAL;
      2'b10:   coin_val = COIN2_VAL;
      default: coin_val = COIN3_VAL;
    endcase
  end

  // One extra bit so a wrap past 255 is still seen as too large.
  assign wide_sum = {1'b0, sum} + {1'b0, coin_val};
  assign overflow = (wide_sum > {1'b0, MAX_SUM});
  assign next_sum = wide_sum[MONEY_W-1:0];

endmodule

// File: rtl/coin_select_handler.sv
// Vending-machine front end: collects coins, checks a selection against its
// price, handles cancel/refund and produces the transaction bundle.
// Ports:
//  clk, rst_n    clock (rising edge), asynchronous active-low reset
//  coin_valid    coin strobe, coin_type its denomination
//  sel_valid     item-button strobe, sel_item the item index
//  cancel        refund request strobe
//  end_trans     one-cycle bundle-valid pulse (refund qualifies it)
//  sum_money     accumulated credit, price / item_select latched selection
//  coin_reject   coin returned pulse, insufficient selection refused pulse
module coin_select_handler
  import vm_pkg::*;
#(
  parameter logic [MONEY_W-1:0] COIN0_VAL = DEF_COIN0_VAL,
  parameter logic [MONEY_W-1:0] COIN1_VAL = DEF_COIN1_VAL,
  parameter logic [MONEY_W-1:0] COIN2_VAL = DEF_COIN2_VAL,
  parameter logic [MONEY_W-1:0] COIN3_VAL = DEF_COIN3_VAL,
  parameter logic [MONEY_W-1:0] PRICE0    = DEF_PRICE0,
  parameter logic [MONEY_W-1:0] PRICE1    = DEF_PRICE1,
  parameter logic [MONEY_W-1:0] PRICE2    = DEF_PRICE2,
  parameter logic [MONEY_W-1:0] PRICE3    = DEF_PRICE3,
  parameter logic [MONEY_W-1:0] MAX_SUM   = DEF_MAX_SUM
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               coin_valid,
  input  logic [1:0]         coin_type,
  input  logic               sel_valid,
  input  logic [1:0]         sel_item,
  input  logic               cancel,
  output logic               end_trans,
  output logic               refund,
  output logic [MONEY_W-1:0] sum_money,
  output logic [MONEY_W-1:0] price,
  output logic [1:0]         item_select,
  output logic               coin_reject,
  output logic               insufficient
);

  state_t             state, state_next;
  logic [MONEY_W-1:0] sum_next, price_next, eff_sum, sel_price;
  logic [1:0]         item_next;
  logic               end_next, refund_next, reject_next, insuff_next;
  logic [MONEY_W-1:0] acc_sum;
  logic               acc_overflow;

  coin_accumulator #(
    .COIN0_VAL (COIN0_VAL),
    .COIN1_VAL (COIN1_VAL),
    .COIN2_VAL (COIN2_VAL),
    .COIN3_VAL (COIN3_VAL),
    .MAX_SUM   (MAX_SUM)
  ) u_acc (
    .sum       (sum_money),
    .coin_type (coin_type),
    .next_sum  (acc_sum),
    .overflow  (acc_overflow)
  );

  always_comb begin
    sel_price = PRICE0;
    case (sel_item)
      2'b00:   sel_price = PRICE0;
      2'b01:   sel_price = PRICE1;
      2'b10:   sel_price = PRICE2;
      default: sel_price = PRICE3;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sum_money    <= '0;
      price        <= '0;
      item_select  <= 2'b00;
      end_trans    <= 1'b0;
      refund       <= 1'b0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
    end else begin
      state        <= state_next;
      sum_money    <= sum_next;
      price        <= price_next;
      item_select  <= item_next;
      end_trans    <= end_next;
      refund       <= refund_next;
      coin_reject  <= reject_next;
      insufficient <= insuff_next;
    end
  end

  always_comb begin
    state_next  = state;
    sum_next    = sum_money;
    price_next  = price;
    item_next   = item_select;
    end_next    = 1'b0;
    refund_next = 1'b0;
    reject_next = 1'b0;
    insuff_next = 1'b0;
    eff_sum     = sum_money;

    case (state)
      IDLE, COLLECT: begin
        if (cancel && state == COLLECT) begin
          // Refund: bundle carries the whole credit as change, any
          // simultaneous coin goes straight back.
          price_next  = '0;
          refund_next = 1'b1;
          end_next    = 1'b1;
          reject_next = coin_valid;
          state_next  = DONE;
        end else begin
          if (coin_valid) begin
            if (acc_overflow) begin
              reject_next = 1'b1;
            end else begin
              sum_next   = acc_sum;
              eff_sum    = acc_sum;
              state_next = COLLECT;
            end
          end
          // Price check sees the credit including a same-cycle coin.
          if (sel_valid && state == COLLECT) begin
            if (eff_sum >= sel_price) begin
              item_next  = sel_item;
              price_next = sel_price;
              end_next   = 1'b1;
              state_next = DONE;
            end else begin
              insuff_next = 1'b1;
            end
          end
        end
      end
      DONE: begin
        // Bundle has been presented; close the transaction.
        sum_next    = '0;
        price_next  = '0;
        reject_next = coin_valid;
        state_next  = IDLE;
      end
      default: begin
        sum_next   = '0;
        price_next = '0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_coin_select_handler.sv
// Directed self-checking bench for coin_select_handler.
module tb_coin_select_handler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = 2'b00;
  logic       cancel = 1'b0;
  logic       end_trans, refund, coin_reject, insufficient;
  logic [7:0] sum_money, price;
  logic [1:0] item_select;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  coin_select_handler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .sel_valid    (sel_valid),
    .sel_item     (sel_item),
    .cancel       (cancel),
    .end_trans    (end_trans),
    .refund       (refund),
    .sum_money    (sum_money),
    .price        (price),
    .item_select  (item_select),
    .coin_reject  (coin_reject),
    .insufficient (insufficient)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Apply strobes for exactly one rising edge; outputs are then sampled
  // 1 ns after that edge, i.e. they show the registered response.
  task automatic pulse(input logic cv, input logic [1:0] ct,
                       input logic sv, input logic [1:0] si, input logic cc);
    coin_valid = cv; coin_type = ct; sel_valid = sv; sel_item = si; cancel = cc;
    @(posedge clk); #1;
    coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
  endtask

  task automatic coin(input logic [1:0] ct);
    pulse(1'b1, ct, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic sel(input logic [1:0] si);
    pulse(1'b0, 2'b00, 1'b1, si, 1'b0);
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst end_trans", end_trans, 0);
    check("rst sum", sum_money, 0);
    check("rst price", price, 0);
    check("rst item", item_select, 0);
    check("rst pulses", {refund, coin_reject, insufficient}, 0);
    rst_n = 1'b1;
    idle();

    // 1: 10 + 10 + 5 = 25, buy item1 (25)
    coin(2'b01); idle();
    coin(2'b01); idle();
    coin(2'b00);
    check("t1 sum", sum_money, 25);
    idle();
    sel(2'b01);
    check("t1 end_trans", end_trans, 1);
    check("t1 price", price, 25);
    check("t1 item", item_select, 1);
    check("t1 refund", refund, 0);
    check("t1 bundle sum", sum_money, 25);
    idle();
    check("t1 end_trans off", end_trans, 0);
    check("t1 sum cleared", sum_money, 0);
    check("t1 price cleared", price, 0);

    // 2: 20 < 45 refused, then +50 = 70 buys item3
    coin(2'b10);
    sel(2'b11);
    check("t2 insufficient", insufficient, 1);
    check("t2 no end_trans", end_trans, 0);
    check("t2 sum kept", sum_money, 20);
    idle();
    check("t2 insufficient off", insufficient, 0);
    coin(2'b11);
    sel(2'b11);
    check("t2 end_trans", end_trans, 1);
    check("t2 sum", sum_money, 70);
    check("t2 price", price, 45);
    check("t2 item", item_select, 3);
    idle();

    // 3: 50 + 5, cancel -> refund of 55
    coin(2'b11);
    coin(2'b00);
    pulse(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    check("t3 end_trans", end_trans, 1);
    check("t3 refund", refund, 1);
    check("t3 price", price, 0);
    check("t3 sum", sum_money, 55);
    idle();
    check("t3 refund off", refund, 0);
    check("t3 end_trans off", end_trans, 0);
    check("t3 sum cleared", sum_money, 0);
    check("t3 item held", item_select, 3);

    // 4: 5x50 = 250, +10 rejected, +5 = 255 accepted
    for (int i = 0; i < 5; i++) coin(2'b11);
    check("t4 sum 250", sum_money, 250);
    coin(2'b01);
    check("t4 reject", coin_reject, 1);
    check("t4 sum kept", sum_money, 250);
    idle();
    check("t4 reject off", coin_reject, 0);
    coin(2'b00);
    check("t4 sum 255", sum_money, 255);
    check("t4 no reject", coin_reject, 0);
    pulse(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    check("t4 refund sum", sum_money, 255);
    idle();

    // 5: sum 5, coin 10 + select item0 together -> 15 >= 15
    coin(2'b00);
    pulse(1'b1, 2'b01, 1'b1, 2'b00, 1'b0);
    check("t5 end_trans", end_trans, 1);
    check("t5 sum", sum_money, 15);
    check("t5 price", price, 15);
    check("t5 item", item_select, 0);
    coin(2'b11);
    check("t5 done reject", coin_reject, 1);
    check("t5 sum cleared", sum_money, 0);
    check("t5 end_trans off", end_trans, 0);
    idle();

    // 6: async reset mid-COLLECT
    coin(2'b11);
    coin(2'b10);
    check("t6 sum 70", sum_money, 70);
    #3 rst_n = 1'b0;
    #1;
    check("t6 async sum", sum_money, 0);
    check("t6 async outs", {end_trans, refund, coin_reject, insufficient, price, item_select}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    sel(2'b00);
    check("t6 sel idle end_trans", end_trans, 0);
    check("t6 sel idle insufficient", insufficient, 0);
    pulse(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    check("t6 cancel idle", {end_trans, refund}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
